// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 64;

  localparam logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    OUT   = 2'd2,
    DRAIN = 2'd3
  } ifetch_state_t;

endpackage

// File: rtl/ifetch.sv
// Instruction fetch: latches the PC, issues one outstanding bus request,
// captures the returned word and hands it to decode with valid/ready.
// A flush while a request is outstanding drains the response before the
// next fetch starts.
// Optional feature macro: IFETCH_MISALIGN_EN (misaligned PCs skip the bus
// and deliver NOP_INST with inst_misalign=1).
module ifetch #(
  parameter logic [ifu_pkg::ADDR_W-1:0] RESET_PC = ifu_pkg::RESET_PC,
  parameter logic [ifu_pkg::INST_W-1:0] NOP_INST = ifu_pkg::NOP_INST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ifu_pkg::ADDR_W-1:0] pc_i,
  output logic                       fetch_stall,
  input  logic                       flush,
  output logic                       ireq_valid,
  output logic [ifu_pkg::ADDR_W-1:0] ireq_addr,
  input  logic                       iresp_data_ok,
  input  logic [ifu_pkg::INST_W-1:0] iresp_data,
  output logic                       inst_valid,
  output logic [ifu_pkg::INST_W-1:0] inst,
  output logic [ifu_pkg::ADDR_W-1:0] inst_pc,
  input  logic                       id_ready,
  output logic                       inst_misalign
);
  import ifu_pkg::*;

  ifetch_state_t       state;
  ifetch_state_t       state_n;
  logic [ADDR_W-1:0]   req_addr;
  logic [INST_W-1:0]   inst_r;
  logic                misalign_hit;
  logic                fetch_start;

`ifdef IFETCH_MISALIGN_EN
  logic                misalign_r;
  assign misalign_hit  = |pc_i[1:0];
  assign inst_misalign = misalign_r;
`else
  assign misalign_hit  = 1'b0;
  assign inst_misalign = 1'b0;
`endif

  // A new fetch begins whenever the unit is idle and not being redirected.
  assign fetch_start = (state == IDLE) && !flush;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; flush outranks id_ready, and a flushed request is
  // drained until its response arrives so the bus never drops mid-transfer.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (!flush) state_n = misalign_hit ? OUT : REQ;
      end
      REQ: begin
        if (iresp_data_ok)  state_n = flush ? IDLE : OUT;
        else if (flush)     state_n = DRAIN;
      end
      OUT: begin
        if (flush || id_ready) state_n = IDLE;
      end
      DRAIN: begin
        if (iresp_data_ok) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State-decoded outputs; the PC register advances only when fetch_stall is low.
  always_comb begin
    ireq_valid  = 1'b0;
    inst_valid  = 1'b0;
    fetch_stall = 1'b1;
    case (state)
      IDLE: begin
        fetch_stall = !flush;
      end
      REQ: begin
        ireq_valid  = 1'b1;
        fetch_stall = !flush;
      end
      OUT: begin
        inst_valid  = 1'b1;
        fetch_stall = !(id_ready || flush);
      end
      DRAIN: begin
        ireq_valid  = 1'b1;
        fetch_stall = 1'b1;
      end
      default: begin
        fetch_stall = 1'b1;
      end
    endcase
  end

  // Request address and captured instruction word.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr <= RESET_PC;
      inst_r   <= '0;
    end else begin
      if (fetch_start) req_addr <= pc_i;
      if (fetch_start && misalign_hit)
        inst_r <= NOP_INST;
      else if ((state == REQ) && iresp_data_ok && !flush)
        inst_r <= iresp_data;
    end
  end

`ifdef IFETCH_MISALIGN_EN
  // Misalign flag rides with the NOP it marks and clears once that NOP leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else if (fetch_start && misalign_hit) begin
      misalign_r <= 1'b1;
    end else if ((state == OUT) && (flush || id_ready)) begin
      misalign_r <= 1'b0;
    end
  end
`endif

  assign ireq_addr = req_addr;
  assign inst      = inst_r;
  assign inst_pc   = req_addr;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a directed per-cycle vector table followed by a
// randomized run checked against a transaction-level reference model.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_i;
  logic        fetch_stall;
  logic        flush;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        id_ready;
  logic        inst_misalign;

  int n_total = 0;
  int n_pass  = 0;

  ifetch dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .fetch_stall   (fetch_stall),
    .flush         (flush),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .id_ready      (id_ready),
    .inst_misalign (inst_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [63:0] pc;
    bit          flush;
    bit          dok;
    logic [31:0] data;
    bit          rdy;
    bit          chk;
    bit          stall;
    bit          rv;
    logic [63:0] addr;
    bit          iv;
    logic [31:0] inst;
    logic [63:0] ipc;
    bit          chk_inst;
    bit          mis;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask

  task automatic row(input bit r, input logic [63:0] pc, input bit fl, input bit dok,
                     input logic [31:0] data, input bit rdy, input bit chk, input bit stall,
                     input bit rv, input logic [63:0] addr, input bit iv, input logic [31:0] ins,
                     input logic [63:0] ipc, input bit ci, input bit mis);
    vec_t v;
    v = '{r, pc, fl, dok, data, rdy, chk, stall, rv, addr, iv, ins, ipc, ci, mis};
    tbl.push_back(v);
  endtask

  task automatic drive(input bit r, input logic [63:0] pc, input bit fl, input bit dok,
                       input logic [31:0] data, input bit rdy);
    @(negedge clk);
    rst = r; pc_i = pc; flush = fl; iresp_data_ok = dok; iresp_data = data; id_ready = rdy;
    #1;
  endtask

  // Reference model: an outstanding request (possibly dead after a redirect)
  // and at most one instruction waiting for decode.
  bit          m_req, m_dead, m_have, m_mis;
  logic [63:0] m_req_pc, m_ipc;
  logic [31:0] m_inst;

  localparam bit MIS_EN =
`ifdef IFETCH_MISALIGN_EN
    1'b1;
`else
    1'b0;
`endif

  task automatic model_reset();
    m_req = 0; m_dead = 0; m_have = 0; m_mis = 0;
    m_req_pc = 64'h8000_0000; m_ipc = '0; m_inst = '0;
  endtask

  function automatic bit model_stall(input bit fl, input bit rdy);
    if (m_have) return !(rdy || fl);
    if (m_req && m_dead) return 1'b1;
    return !fl;
  endfunction

  task automatic model_step(input logic [63:0] pc, input bit fl, input bit dok,
                            input logic [31:0] data, input bit rdy);
    if (m_have) begin
      if (fl || rdy) begin m_have = 0; m_mis = 0; end
    end else if (m_req) begin
      if (dok) begin
        m_req = 0;
        if (!m_dead && !fl) begin m_have = 1; m_inst = data; m_ipc = m_req_pc; end
      end else if (fl) begin
        m_dead = 1;
      end
    end else if (!fl) begin
      if (MIS_EN && pc[1:0] != 2'b00) begin
        m_have = 1; m_inst = 32'h0000_0013; m_ipc = pc; m_mis = 1;
      end else begin
        m_req = 1; m_dead = 0; m_req_pc = pc;
      end
    end
  endtask

  initial begin
    logic [63:0] pc;
    bit          fl, dok, rdy, r, st;
    logic [31:0] data;

    rst = 1; pc_i = 64'h8000_0000; flush = 0; iresp_data_ok = 0; iresp_data = '0; id_ready = 0;

    // rst pc fl dok data rdy | chk stall rv addr iv inst ipc chk_inst mis
    row(1, 64'h8000_0000, 0, 0, 32'h0, 1,  0, 1, 0, 64'h0, 0, 32'h0, 64'h0, 0, 0);
    row(1, 64'h8000_0000, 0, 0, 32'h0, 1,  0, 1, 0, 64'h0, 0, 32'h0, 64'h0, 0, 0);
    // zero-wait fetch: request in cycle 1, instruction in cycle 2
    row(0, 64'h8000_0000, 0, 0, 32'h0,        1, 1, 1, 0, 64'h0,          0, 32'h0,        64'h0,          1, 0);
    row(0, 64'h8000_0000, 0, 1, 32'h00500093, 1, 1, 1, 1, 64'h8000_0000, 0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0000, 0, 0, 32'h0,        1, 1, 0, 0, 64'h0,          1, 32'h00500093, 64'h8000_0000, 0, 0);
    row(0, 64'h8000_0004, 0, 0, 32'h0,        1, 1, 1, 0, 64'h0,          0, 32'h0,        64'h0,          0, 0);
    // three-cycle memory latency, then decode stalls for four cycles
    row(0, 64'h8000_0004, 0, 0, 32'h0,        0, 1, 1, 1, 64'h8000_0004, 0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0004, 0, 0, 32'h0,        0, 1, 1, 1, 64'h8000_0004, 0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0004, 0, 1, 32'h00A00113, 0, 1, 1, 1, 64'h8000_0004, 0, 32'h0,        64'h0,          0, 0);
    for (int i = 0; i < 4; i++)
      row(0, 64'h8000_0004, 0, 0, 32'h0,      0, 1, 1, 0, 64'h0,          1, 32'h00A00113, 64'h8000_0004, 0, 0);
    row(0, 64'h8000_0004, 0, 0, 32'h0,        1, 1, 0, 0, 64'h0,          1, 32'h00A00113, 64'h8000_0004, 0, 0);
    row(0, 64'h8000_0008, 0, 0, 32'h0,        1, 1, 1, 0, 64'h0,          0, 32'h0,        64'h0,          0, 0);
    // flush in REQ: drain old request, discard its response, refetch from redirect
    row(0, 64'h8000_0008, 1, 0, 32'h0,        1, 1, 0, 1, 64'h8000_0008, 0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0100, 0, 0, 32'h0,        1, 1, 1, 1, 64'h8000_0008, 0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0100, 0, 1, 32'hFFFFFFFF, 1, 1, 1, 1, 64'h8000_0008, 0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0100, 0, 0, 32'h0,        1, 1, 1, 0, 64'h0,          0, 32'h0,        64'h0,          0, 0);
    // data_ok together with flush: nothing delivered
    row(0, 64'h8000_0100, 1, 1, 32'h12345678, 1, 1, 0, 1, 64'h8000_0100, 0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0200, 0, 0, 32'h0,        1, 1, 1, 0, 64'h0,          0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0200, 0, 1, 32'h00000533, 1, 1, 1, 1, 64'h8000_0200, 0, 32'h0,        64'h0,          0, 0);
    // flush in OUT with id_ready: flush wins, then idle
    row(0, 64'h8000_0200, 1, 0, 32'h0,        1, 1, 0, 0, 64'h0,          1, 32'h00000533, 64'h8000_0200, 0, 0);
    row(0, 64'h8000_0300, 0, 0, 32'h0,        1, 1, 1, 0, 64'h0,          0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0300, 0, 1, 32'h00100073, 1, 1, 1, 1, 64'h8000_0300, 0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0300, 0, 0, 32'h0,        1, 1, 0, 0, 64'h0,          1, 32'h00100073, 64'h8000_0300, 0, 0);
    // flush in IDLE: no latch
    row(0, 64'h8000_0304, 1, 0, 32'h0,        1, 1, 0, 0, 64'h0,          0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0400, 0, 0, 32'h0,        1, 1, 1, 0, 64'h0,          0, 32'h0,        64'h0,          0, 0);
    // flush repeated while draining stays in drain
    row(0, 64'h8000_0400, 0, 0, 32'h0,        1, 1, 1, 1, 64'h8000_0400, 0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0400, 1, 0, 32'h0,        1, 1, 0, 1, 64'h8000_0400, 0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0500, 1, 0, 32'h0,        1, 1, 1, 1, 64'h8000_0400, 0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0500, 0, 1, 32'h0BADF00D, 1, 1, 1, 1, 64'h8000_0400, 0, 32'h0,        64'h0,          0, 0);
    // misaligned PC
    row(0, 64'h8000_0002, 0, 0, 32'h0,        1, 1, 1, 0, 64'h0,          0, 32'h0,        64'h0,          0, 0);
`ifdef IFETCH_MISALIGN_EN
    row(0, 64'h8000_0002, 0, 0, 32'h0,        1, 1, 0, 0, 64'h0,          1, 32'h00000013, 64'h8000_0002, 0, 1);
`else
    row(0, 64'h8000_0002, 0, 1, 32'h00000093, 1, 1, 1, 1, 64'h8000_0002, 0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0002, 0, 0, 32'h0,        1, 1, 0, 0, 64'h0,          1, 32'h00000093, 64'h8000_0002, 0, 0);
`endif
    // reset while a request is outstanding abandons it
    row(0, 64'h8000_0500, 0, 0, 32'h0,        1, 1, 1, 0, 64'h0,          0, 32'h0,        64'h0,          0, 0);
    row(1, 64'h8000_0500, 0, 0, 32'h0,        1, 1, 1, 1, 64'h8000_0500, 0, 32'h0,        64'h0,          0, 0);
    row(0, 64'h8000_0000, 0, 0, 32'h0,        1, 1, 1, 0, 64'h0,          0, 32'h0,        64'h0,          1, 0);

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      drive(v.rst, v.pc, v.flush, v.dok, v.data, v.rdy);
      if (v.chk) begin
        check($sformatf("vec%0d.fetch_stall", i), {63'd0, fetch_stall}, {63'd0, v.stall});
        check($sformatf("vec%0d.ireq_valid", i), {63'd0, ireq_valid}, {63'd0, v.rv});
        if (v.rv) check($sformatf("vec%0d.ireq_addr", i), ireq_addr, v.addr);
        check($sformatf("vec%0d.inst_valid", i), {63'd0, inst_valid}, {63'd0, v.iv});
        if (v.iv || v.chk_inst) check($sformatf("vec%0d.inst", i), {32'd0, inst}, {32'd0, v.inst});
        if (v.iv) check($sformatf("vec%0d.inst_pc", i), inst_pc, v.ipc);
        check($sformatf("vec%0d.inst_misalign", i), {63'd0, inst_misalign}, {63'd0, v.mis});
      end
    end

    // randomized run against the reference model
    drive(1, 64'h8000_0000, 0, 0, 32'h0, 0);
    model_reset();
    pc = 64'h8000_0000;
    for (int c = 0; c < 3000; c++) begin
      r    = ($urandom_range(0, 299) == 0);
      fl   = ($urandom_range(0, 7) == 0);
      rdy  = ($urandom_range(0, 1) == 1);
      dok  = m_req && ($urandom_range(0, 2) == 0);
      data = $urandom;
      drive(r, pc, fl, dok, data, rdy);
      st = model_stall(fl, rdy);
      check("rnd.fetch_stall", {63'd0, fetch_stall}, {63'd0, st});
      check("rnd.ireq_valid", {63'd0, ireq_valid}, {63'd0, m_req});
      if (m_req) check("rnd.ireq_addr", ireq_addr, m_req_pc);
      check("rnd.inst_valid", {63'd0, inst_valid}, {63'd0, m_have});
      if (m_have) begin
        check("rnd.inst", {32'd0, inst}, {32'd0, m_inst});
        check("rnd.inst_pc", inst_pc, m_ipc);
      end
      check("rnd.inst_misalign", {63'd0, inst_misalign}, {63'd0, m_have && m_mis});
      if (r) begin
        model_reset();
        pc = 64'h8000_0000;
      end else begin
        model_step(pc, fl, dok, data, rdy);
        if (fl)
          pc = 64'h8000_0000 + 64'({$urandom_range(0, 1023), 2'b00})
               + (($urandom_range(0, 7) == 0) ? 64'd2 : 64'd0);
        else if (!st)
          pc = pc + 64'd4;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Fetch-side consumer of the PC register's fetch address.
- Latches the current PC and issues a single-outstanding request on the instruction bus.
- Captures the returned 32-bit instruction and presents it to decode with a valid/ready handshake.
- Drives the stall that holds the PC register while a fetch is in flight; handles redirect (flush) at any point, including with a request outstanding.

Parameters:
- RESET_PC, 64'h8000_0000, reset value of the latched request address
- NOP_INST, 32'h0000_0013, instruction word presented on a suppressed fetch

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- pc_i  input  64  current PC from the PC register
- fetch_stall  output  1  holds the PC register when 1
- flush  input  1  redirect this cycle; PC register loads its redirect target
- ireq_valid  output  1  instruction bus request
- ireq_addr  output  64  request address, stable while ireq_valid=1
- iresp_data_ok  input  1  one-cycle response strobe, may arrive in the same cycle as ireq_valid
- iresp_data  input  32  instruction word, valid with iresp_data_ok
- inst_valid  output  1  instruction available to decode
- inst  output  32  instruction word
- inst_pc  output  64  address of inst
- id_ready  input  1  decode accepts inst this cycle
- inst_misalign  output  1  fetch address misaligned (optional feature; 0 otherwise)

Behaviour:
- Sync reset, active-high, one clock. Reset values:
  - state=IDLE
  - req_addr=RESET_PC
  - inst=0, inst_valid=0, ireq_valid=0, inst_misalign=0
- Reset mid-request abandons the request; the bus shares the same rst.
- States and transitions:
  - IDLE: ireq_valid=0, fetch_stall=!flush. If !flush: req_addr<=pc_i, go REQ. If flush: stay IDLE, no latch.
  - REQ: ireq_valid=1, ireq_addr=req_addr, fetch_stall=!flush.
    - data_ok & !flush: inst<=iresp_data, go OUT.
    - data_ok & flush: discard, go IDLE.
    - !data_ok & flush: go DRAIN.
    - otherwise stay in REQ.
  - OUT: inst_valid=1, inst_pc=req_addr, fetch_stall=!(id_ready|flush).
    - flush: drop inst, go IDLE.
    - id_ready: go IDLE.
    - otherwise hold inst stable.
  - DRAIN: ireq_valid=1 with the old req_addr, fetch_stall=1, inst_valid=0.
    - data_ok: discard, go IDLE.
    - flush in DRAIN stays DRAIN.
- Bus rule: ireq_valid never drops before data_ok, except on rst.
- Latency: zero-wait-state memory gives IDLE→REQ→OUT, inst_valid 2 cycles after the PC is latched. Steady-state throughput is 1 inst per 3 cycles with id_ready=1.
- fetch_stall=0 for exactly one cycle per consumed instruction, or for a flush cycle. The PC register advances on that edge.
- flush has priority over id_ready. Simultaneous data_ok and flush in REQ never produces inst_valid.
- inst_valid, inst and inst_pc are registered/state-decoded and glitch-free. ireq_addr=req_addr at all times.

Optional Feature:
- Macro IFETCH_MISALIGN_EN.
- Defined:
  - In IDLE (no flush), if pc_i[1:0]!=0: latch req_addr, set inst<=NOP_INST and inst_misalign<=1, go directly to OUT with no bus request.
  - inst_misalign is cleared when leaving OUT.
- Undefined:
  - No check is made; the address is issued as-is.
  - inst_misalign is tied to 0.

Decomposition:
- Package ifu_pkg holds:
  - state enum ifetch_state_t {IDLE, REQ, OUT, DRAIN}
  - RESET_PC constant 64'h8000_0000
  - NOP_INST constant 32'h0000_0013
  - INST_W=32, ADDR_W=64
- Single module; no sub-module is warranted.

Test Plan:
- Reset release, pc_i=0x8000_0000, memory answers data_ok in the same cycle with 0x00500093, id_ready=1 -> ireq_valid at cycle 1 with addr 0x8000_0000; inst_valid at cycle 2 with inst=0x00500093, inst_pc=0x8000_0000; fetch_stall=0 only in cycle 2.
- Memory latency 3 cycles -> ireq_valid held 3 cycles with a stable address; fetch_stall=1 throughout; one inst_valid pulse after.
- id_ready=0 for 4 cycles in OUT -> inst/inst_pc held, fetch_stall=1; on id_ready=1 exactly one handoff, then IDLE.
- flush in REQ cycle 1 with data_ok at cycle 3 -> DRAIN with the old address held; the response is discarded; no inst_valid; the next request uses the redirected pc_i=0x8000_0100.
- data_ok and flush in the same cycle; and flush in OUT with id_ready=1 -> no instruction delivered, state IDLE next cycle.
- IFETCH_MISALIGN_EN defined, pc_i=0x8000_0002 -> no ireq_valid; inst_valid with inst=0x00000013, inst_misalign=1. Undefined -> request issued to 0x8000_0002.
